// File: rtl/hsaf_pkg.sv
// Shared definitions for the sign-sign LMS tap-weight engine: FSM states and
// width helpers used to size the accumulator and tap index.
package hsaf_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC      = 2'd1,
        WAIT_ERR = 2'd2,
        UPDATE   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Wide enough that N full-precision products can never overflow.
    function automatic int acc_width(input int bitsize, input int wsize, input int n);
        return bitsize + wsize + clog2(n);
    endfunction

endpackage

// File: rtl/hsaf_sat_step.sv
// One sign-sign LMS step for a single weight: move by +/-STEP toward the
// product of the sample and error signs, clamped to the signed weight range.
module hsaf_sat_step #(
    parameter int WSIZE = 8,
    parameter int STEP  = 1
) (
    input  logic signed [WSIZE-1:0] w_i,
    input  logic                    x_zero_i,
    input  logic                    x_neg_i,
    input  logic                    e_neg_i,
    output logic signed [WSIZE-1:0] w_o
);

    localparam logic signed [WSIZE:0] STEP_W = (WSIZE+1)'(STEP);
    localparam logic signed [WSIZE:0] W_MAX  = (WSIZE+1)'((1 << (WSIZE-1)) - 1);
    localparam logic signed [WSIZE:0] W_MIN  = (WSIZE+1)'(-(1 << (WSIZE-1)));

    logic signed [WSIZE:0] w_ext;
    logic signed [WSIZE:0] sum;

    // One guard bit is enough because STEP stays below half the weight range.
    always_comb begin
        w_ext = {w_i[WSIZE-1], w_i};
        sum   = w_ext;
        if (!x_zero_i) begin
            if (x_neg_i == e_neg_i) sum = w_ext + STEP_W;
            else                    sum = w_ext - STEP_W;
        end
        if (sum > W_MAX)      w_o = W_MAX[WSIZE-1:0];
        else if (sum < W_MIN) w_o = W_MIN[WSIZE-1:0];
        else                  w_o = sum[WSIZE-1:0];
    end

endmodule

// File: rtl/hsaf_mac_update.sv
// Serial dot product of a latched sample window against an internal weight
// bank, followed by a sign-sign LMS update driven by the returned error.
module hsaf_mac_update
    import hsaf_pkg::*;
#(
    parameter int BITSIZE = 8,
    parameter int N       = 16,
    parameter int WSIZE   = 8,
    parameter int STEP    = 1,
    localparam int ACC_W  = acc_width(BITSIZE, WSIZE, N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*BITSIZE-1:0]      win_packed,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [ACC_W-1:0]   y,
    output logic                      y_valid,
    input  logic [BITSIZE-1:0]        err,
    input  logic                      err_valid,
    output logic [N*WSIZE-1:0]        w_packed,
    output state_t                    state_o
);

    localparam int IDX_W              = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam int PROD_W             = BITSIZE + WSIZE;

    state_t state_q, state_d;

    logic [N*BITSIZE-1:0]     win_q, win_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     e_neg_q, e_neg_d;
    logic signed [WSIZE-1:0]  w_q [N];
    logic signed [WSIZE-1:0]  w_d [N];

    logic signed [BITSIZE-1:0] x_cur;
    logic signed [WSIZE-1:0]   w_cur;
    logic signed [WSIZE-1:0]   w_upd;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      last_tap;
    logic                      accept;
    logic                      err_take;

    assign x_cur    = win_q[BITSIZE*idx_q +: BITSIZE];
    assign w_cur    = w_q[idx_q];
    assign prod     = PROD_W'(x_cur) * PROD_W'(w_cur);
    assign acc_sum  = acc_q + ACC_W'(prod);
    assign last_tap = (idx_q == LAST);

    hsaf_sat_step #(
        .WSIZE (WSIZE),
        .STEP  (STEP)
    ) u_sat_step (
        .w_i      (w_cur),
        .x_zero_i (x_cur == '0),
        .x_neg_i  (x_cur[BITSIZE-1]),
        .e_neg_i  (e_neg_q),
        .w_o      (w_upd)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (in_valid) state_d = MAC;
            MAC:      if (last_tap) state_d = WAIT_ERR;
            WAIT_ERR: if (err_valid) state_d = (err == '0) ? IDLE : UPDATE;
            UPDATE:   if (last_tap) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Handshakes: a window transfers on an edge where in_valid && in_ready;
    // an error transfers on an edge where err_valid is high in WAIT_ERR.
    always_comb begin
        in_ready = (state_q == IDLE);
        accept   = in_ready && in_valid;
        err_take = (state_q == WAIT_ERR) && err_valid;
    end

    always_comb begin
        win_d     = win_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        idx_d     = idx_q;
        e_neg_d   = e_neg_q;
        for (int i = 0; i < N; i++) w_d[i] = w_q[i];

        if (accept) begin
            win_d = win_packed;
            acc_d = '0;
            idx_d = '0;
        end
        if (state_q == MAC) begin
            acc_d = acc_sum;
            idx_d = last_tap ? '0 : idx_q + IDX_W'(1);
            if (last_tap) begin
                y_d       = acc_sum;
                y_valid_d = 1'b1;
            end
        end
        if (err_take) begin
            e_neg_d = err[BITSIZE-1];
            idx_d   = '0;
        end
        if (state_q == UPDATE) begin
            w_d[idx_q] = w_upd;
            idx_d      = last_tap ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            idx_q     <= '0;
            e_neg_q   <= 1'b0;
            for (int i = 0; i < N; i++) w_q[i] <= '0;
        end else begin
            win_q     <= win_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
            e_neg_q   <= e_neg_d;
            for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_wpack
        assign w_packed[WSIZE*g +: WSIZE] = w_q[g];
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign state_o = state_q;

endmodule
